// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a length-prefixed image into instruction RAM,
// then releases and watches the core. Optional run limit: BOOT_WATCHDOG_EN.
module boot_sequencer #(
  parameter int ADDR_W          = 10,
  parameter int RST_HOLD        = 2,
  parameter int WATCHDOG_CYCLES = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  input  logic [31:0]       core_idata,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [31:0]       cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_REL,
    S_RUN,
    S_HALT,
    S_ERR
  } state_e;

  localparam int HOLD_W =
    (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RST_HOLD - 1);
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);
  localparam logic [31:0] WD_LIM =
    32'(WATCHDOG_CYCLES);

  state_e state_q, state_d;

  logic [7:0]        nlo_q, nlo_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       cyc_q, cyc_d;

  logic        xfer;
  logic        start_ok;
  logic [15:0] n_full;
  logic        hdr_bad;
  logic        last_word;
  logic        halt_hit;
  logic        wd_hit;
  logic [31:0] cyc_inc;

  assign xfer     = rx_valid & rx_ready;
  assign start_ok = start &&
    (state_q == S_IDLE || state_q == S_HALT ||
     state_q == S_ERR);
  assign n_full   = {rx_data, nlo_q};
  assign hdr_bad  = (n_full == 16'd0) ||
    ({1'b0, n_full} > CAP);
  assign last_word = (state_q == S_LOAD) && xfer &&
    (lane_q == 2'd3) && (ptr_q == last_q);
  // first RUN cycle has cycles==0: fetch still settling
  assign halt_hit = (state_q == S_RUN) &&
    (cyc_q != 32'd0) && (core_idata == 32'd0);
  assign cyc_inc  = (cyc_q == 32'hFFFF_FFFF) ?
    cyc_q : cyc_q + 32'd1;

`ifdef BOOT_WATCHDOG_EN
  assign wd_hit = (state_q == S_RUN) &&
    (cyc_inc == WD_LIM);
`else
  // no run limit in this build
  assign wd_hit = 1'b0 && (cyc_inc == WD_LIM);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) state_d = S_HDR0;
        end
        S_HDR0: begin
          if (xfer) state_d = S_HDR1;
        end
        S_HDR1: begin
          if (xfer) state_d = hdr_bad ? S_ERR : S_LOAD;
        end
        S_LOAD: begin
          if (last_word) state_d = S_REL;
        end
        S_REL: begin
          if (hold_q == HOLD_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (halt_hit)    state_d = S_HALT;
          else if (wd_hit) state_d = S_ERR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    nlo_d   = nlo_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    word_d  = word_q;
    hold_d  = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cyc_d   = cyc_q;
    if (!abort) begin
      if (start_ok) begin
        ptr_d  = '0;
        lane_d = 2'd0;
        cyc_d  = 32'd0;
      end
      if (state_q == S_HDR0 && xfer) nlo_d = rx_data;
      if (state_q == S_HDR1 && xfer) begin
        last_d = ADDR_W'(n_full - 16'd1);
      end
      if (state_q == S_LOAD && xfer) begin
        lane_d = lane_q + 2'd1;
        unique case (lane_q)
          2'd0: word_d[7:0]   = rx_data;
          2'd1: word_d[15:8]  = rx_data;
          2'd2: word_d[23:16] = rx_data;
          2'd3: begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = {rx_data, word_q};
            ptr_d   = ptr_q + 1'b1;
          end
          default: ;
        endcase
      end
      if (state_q == S_REL) hold_d = hold_q + 1'b1;
      if (state_q == S_RUN) cyc_d = cyc_inc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nlo_q   <= '0;
      last_q  <= '0;
      ptr_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
    end else begin
      nlo_q   <= nlo_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    rx_ready  = 1'b0;
    core_rstn = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_HDR0, S_HDR1, S_LOAD: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_REL:  busy = 1'b1;
      S_RUN: begin
        busy      = 1'b1;
        core_rstn = 1'b1;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  err    = 1'b1;
      default: ;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cycles     = cyc_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: scoreboarded image writes plus
// per-scenario status checks.
module tb_boot_sequencer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rstn;
  logic [31:0]   core_idata = 32'h13;
  logic          busy;
  logic          halted;
  logic          err;
  logic [31:0]   cycles;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic          bp = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW+31:0] sb[$];
  logic [AW+31:0] exp_w;

  always #5 clk = ~clk;

  boot_sequencer #(
    .ADDR_W(AW),
    .RST_HOLD(2),
    .WATCHDOG_CYCLES(50)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .start(start),
    .abort(abort),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rstn(core_rstn),
    .core_idata(core_idata),
    .busy(busy),
    .halted(halted),
    .err(err),
    .cycles(cycles)
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL imem_unexpected got=%0d:%h exp=none",
                 imem_addr, imem_wdata);
      end else begin
        exp_w = sb.pop_front();
        if ({imem_addr, imem_wdata} !== exp_w) begin
          fails++;
          $display("FAIL imem_write got=%0d:%h exp=%0d:%h",
                   imem_addr, imem_wdata,
                   exp_w[AW+31:32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "timeout");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    rx_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (bp) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout got=0 exp=1");
    end
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    exp_addr = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    sb.push_back({exp_addr, w});
    exp_addr++;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_rstn();
    int n = 0;
    while (!core_rstn && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (core_rstn !== 1'b1) begin
      fails++;
      $display("FAIL rstn_release got=%b exp=1", core_rstn);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata,
         core_rstn, busy, halted, err, cycles} !== '0) begin
      fails++;
      $display("FAIL reset_vals got=%b%b%h%h%b%b%b%b%h exp=0",
               rx_ready, imem_we, imem_addr, imem_wdata,
               core_rstn, busy, halted, err, cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, rx_ready, core_rstn} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset got=%b%b%b exp=000",
               busy, rx_ready, core_rstn);
    end
  endtask

  task automatic test_nominal();
    int base = wr_cnt;
    pulse_start();
    send_hdr(16'd3);
    send_word(32'h00A00513);
    send_word(32'h00100593);
    send_word(32'h00000000);
    @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if ({imem_we, rx_ready, core_rstn} !== 3'b100) begin
      fails++;
      $display("FAIL nom_last_write got=%b%b%b exp=100",
               imem_we, rx_ready, core_rstn);
    end
    @(negedge clk);
    tests++;
    if ({core_rstn, busy} !== 2'b01) begin
      fails++;
      $display("FAIL nom_hold2 got=%b%b exp=01",
               core_rstn, busy);
    end
    @(negedge clk);
    tests++;
    if ({core_rstn, busy} !== 2'b11) begin
      fails++;
      $display("FAIL nom_release got=%b%b exp=11",
               core_rstn, busy);
    end
    tests++;
    if (wr_cnt - base !== 3) begin
      fails++;
      $display("FAIL nom_wr_count got=%0d exp=3",
               wr_cnt - base);
    end
  endtask

  task automatic test_halt();
    tests++;
    if (cycles !== 32'd0) begin
      fails++;
      $display("FAIL halt_cyc0 got=%0d exp=0", cycles);
    end
    repeat (4) @(negedge clk);
    @(negedge clk);
    core_idata = 32'h0;
    @(negedge clk);
    core_idata = 32'h13;
    tests++;
    if ({halted, core_rstn, busy} !== 3'b100 ||
        cycles !== 32'd6) begin
      fails++;
      $display("FAIL halt_state got=%b%b%b/%0d exp=100/6",
               halted, core_rstn, busy, cycles);
    end
    @(negedge clk);
    tests++;
    if (cycles !== 32'd6) begin
      fails++;
      $display("FAIL halt_frozen got=%0d exp=6", cycles);
    end
  endtask

  task automatic test_hdr_err();
    int base = wr_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    drop();
    tests++;
    if ({err, core_rstn, busy} !== 3'b100) begin
      fails++;
      $display("FAIL hdr_n0 got=%b%b%b exp=100",
               err, core_rstn, busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt !== base) begin
      fails++;
      $display("FAIL hdr_n0_writes got=%0d exp=%0d",
               wr_cnt, base);
    end
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    drop();
    tests++;
    if ({err, busy} !== 2'b10) begin
      fails++;
      $display("FAIL hdr_n1025 got=%b%b exp=10", err, busy);
    end
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    drop();
    tests++;
    if ({err, busy, rx_ready} !== 3'b011) begin
      fails++;
      $display("FAIL hdr_n1024 got=%b%b%b exp=011",
               err, busy, rx_ready);
    end
    do_abort();
    tests++;
    if ({err, busy} !== 2'b00) begin
      fails++;
      $display("FAIL hdr_abort got=%b%b exp=00", err, busy);
    end
  endtask

  task automatic test_backpressure();
    bp = 1'b1;
    pulse_start();
    send_hdr(16'd3);
    for (int i = 0; i < 3; i++) send_word($urandom);
    bp = 1'b0;
    drop();
    wait_rstn();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL bp_pending got=%0d exp=0", sb.size());
    end
    do_abort();
  endtask

  task automatic test_abort();
    int base;
    pulse_start();
    send_hdr(16'd3);
    send_word(32'h11223344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_abort();
    tests++;
    if ({rx_ready, busy, core_rstn} !== 3'b000) begin
      fails++;
      $display("FAIL abort_idle got=%b%b%b exp=000",
               rx_ready, busy, core_rstn);
    end
    base = wr_cnt;
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (wr_cnt !== base || sb.size() !== 0) begin
      fails++;
      $display("FAIL abort_writes got=%0d/%0d exp=%0d/0",
               wr_cnt, sb.size(), base);
    end
    pulse_start();
    send_hdr(16'd1);
    send_word(32'hCAFEF00D);
    drop();
    wait_rstn();
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata,
         core_rstn, busy, halted, err, cycles} !== '0) begin
      fails++;
      $display("FAIL async_rst got=%b%b%b%b%h exp=0",
               core_rstn, busy, halted, err, cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, core_rstn} !== 2'b00) begin
      fails++;
      $display("FAIL async_idle got=%b%b exp=00",
               busy, core_rstn);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w1 = 32'hDEADBEEF;
    pulse_start();
    send_hdr(16'd2);
    send_word(32'h0BADC0DE);
    sb.push_back({exp_addr, w1});
    exp_addr++;
    send_byte(w1[7:0]);
    send_byte(w1[15:8]);
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({busy, rx_ready} !== 2'b11) begin
      fails++;
      $display("FAIL start_ign_state got=%b%b exp=11",
               busy, rx_ready);
    end
    send_byte(w1[23:16]);
    send_byte(w1[31:24]);
    drop();
    wait_rstn();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL start_ign_pending got=%0d exp=0",
               sb.size());
    end
  endtask

  task automatic test_first_cycle();
    do_abort();
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h00000093);
    core_idata = 32'h0;
    drop();
    wait_rstn();
    @(negedge clk);
    tests++;
    if ({halted, busy} !== 2'b01) begin
      fails++;
      $display("FAIL first_cyc_skip got=%b%b exp=01",
               halted, busy);
    end
    @(negedge clk);
    core_idata = 32'h13;
    tests++;
    if (halted !== 1'b1 || cycles !== 32'd2) begin
      fails++;
      $display("FAIL first_cyc_halt got=%b/%0d exp=1/2",
               halted, cycles);
    end
  endtask

  task automatic test_watchdog();
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h00000013);
    drop();
    wait_rstn();
`ifdef BOOT_WATCHDOG_EN
    begin
      int n = 0;
      while (!err && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    tests++;
    if ({err, core_rstn} !== 2'b10 ||
        cycles !== 32'd50) begin
      fails++;
      $display("FAIL watchdog got=%b%b/%0d exp=10/50",
               err, core_rstn, cycles);
    end
`else
    repeat (200) @(negedge clk);
    tests++;
    if ({busy, core_rstn, err} !== 3'b110 ||
        cycles !== 32'd200) begin
      fails++;
      $display("FAIL no_watchdog got=%b%b%b/%0d exp=110/200",
               busy, core_rstn, err, cycles);
    end
`endif
    do_abort();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_halt();
    test_hdr_err();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_ignored();
    test_first_cycle();
    test_watchdog();
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Sequences the CPU core from power-up to halt.
- Holds the core in reset while a program image, streamed in byte by byte, is written into instruction RAM; then releases the core.
- Snoops the fetched instruction word and declares halt on an all-zero instruction.
- Reports status and the run-cycle count; sits between the top level, the byte source (UART/loader), the instruction RAM write port and the core's RSTn.

Parameters:
- ADDR_W, 10, instruction RAM word-address width; capacity is 2^ADDR_W words.
- RST_HOLD, 2, cycles core_rstn is held low after the load completes, before release (minimum 1).
- WATCHDOG_CYCLES, 100000, run-cycle limit; used only when BOOT_WATCHDOG_EN is defined.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE, HALTED or ERROR.
- abort  in  1  synchronous; from any state go to IDLE and drive core_rstn low.
- rx_data  in  8  image byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts a byte; a transfer occurs when rx_valid and rx_ready are both high on a rising edge.
- imem_we  out  1  instruction RAM write strobe.
- imem_addr  out  ADDR_W  instruction RAM word address.
- imem_wdata  out  32  instruction RAM write word.
- core_rstn  out  1  active-low reset to the CPU core.
- core_idata  in  32  instruction word currently fetched by the core.
- busy  out  1  high in HDR0, HDR1, LOAD, RELEASE and RUN.
- halted  out  1  high in HALTED.
- err  out  1  high in ERROR.
- cycles  out  32  RUN-state cycle count.

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rstn=0, busy=0, halted=0, err=0, cycles=0; state IDLE. RST is asynchronous and can act in any state, including mid-load; after RST the load must be restarted with start.
- Image format: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte is bits 7:0).
- States:
  - IDLE: core_rstn=0, rx_ready=0. On start go to HDR0 and clear cycles, word pointer and byte index.
  - HDR0: rx_ready=1. On transfer latch N[7:0] and go to HDR1.
  - HDR1: rx_ready=1. On transfer latch N[15:8].
    - If N==0 or N>2^ADDR_W, go to ERROR.
    - Otherwise go to LOAD.
  - LOAD: rx_ready=1. Transfers fill byte lanes 0..3 in order.
    - The cycle after the 4th byte is accepted: imem_we=1 for exactly 1 cycle, imem_addr=word pointer, imem_wdata=assembled word.
    - The pointer then increments.
    - rx_ready stays high, so back-to-back bytes are legal and incur no stall.
    - After the write of word N-1, go to RELEASE. rx_ready drops in the same cycle as the final byte acceptance plus 1.
  - RELEASE: core_rstn=0 for RST_HOLD cycles, then go to RUN.
  - RUN: core_rstn=1; cycles increments every cycle and saturates at 0xFFFFFFFF.
    - If core_idata==32'h0 on any RUN cycle except the first, go to HALTED.
    - The first RUN cycle is excluded because the fetch is still settling out of reset.
  - HALTED: core_rstn=0; cycles frozen; halted=1. start begins a new load.
  - ERROR: core_rstn=0; err=1. start begins a new load; abort goes to IDLE.
- Simultaneous events:
  - abort has priority over start and over all transitions.
  - start is ignored while busy=1.
- imem_addr wraps never: N is bounded, so the pointer maxes at 2^ADDR_W-1.
- Bytes presented while rx_ready=0 are not consumed.

Optional Feature:
- Macro: BOOT_WATCHDOG_EN.
- Defined: in RUN, when cycles reaches WATCHDOG_CYCLES without a halt, go to ERROR at that edge. core_rstn drops to 0 and cycles holds WATCHDOG_CYCLES.
- Undefined: no limit; RUN continues until halt, abort or RST. WATCHDOG_CYCLES is unused.

Test Plan:
- Nominal load: start; bytes 03 00 then 13 05 A0 00 / 93 05 10 00 / 00 00 00 00 -> three imem_we pulses.
  - Addresses 0,1,2 with data 0x00A00513, 0x00100593, 0x00000000.
  - Then core_rstn low for 2 cycles, then high.
- Halt detection: RUN with core_idata nonzero for 5 cycles, then 0 -> halted=1, core_rstn=0, cycles=6, busy=0.
- Header errors: N=0 -> err=1, no imem_we, core_rstn=0. N=1025 (bytes 01 04) at ADDR_W=10 -> err=1.
- Back-pressure and abort:
  - rx_valid toggled randomly -> words still assembled correctly.
  - abort mid-LOAD after 6 bytes -> IDLE next edge, rx_ready=0, no further writes.
  - A subsequent start loads cleanly from address 0.
- Async reset and start priority:
  - RST asserted mid-RUN off-edge -> all outputs return to reset values immediately.
  - start during LOAD -> ignored.
- Watchdog: BOOT_WATCHDOG_EN defined, WATCHDOG_CYCLES=50, core_idata never 0 -> err=1 with cycles=50 and core_rstn=0.
  - Undefined -> still busy at cycle 200.
